// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA framebuffer path.
//   PIX_W         : width of one framebuffer word / pixel colour {r,g,b}
//   H_ACTIVE_DEF  : default visible pixels per line (shared with vga_hvsync_gen)
//   V_ACTIVE_DEF  : default visible lines (shared with vga_hvsync_gen)
//   swap_state_t  : buffer-swap FSM states
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int PIX_W        = 12;
  localparam int H_ACTIVE_DEF = 1280;
  localparam int V_ACTIVE_DEF = 1024;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } swap_state_t;

endpackage

// File: rtl/vga_delay_line.sv
// ---------------------------------------------------------------------------
// vga_delay_line
// Fixed-depth register pipeline, cleared by reset.
//   clk_i   : clock
//   reset_i : synchronous active-low reset
//   din_i   : WIDTH-bit input
//   dout_o  : din_i delayed by DEPTH cycles
// ---------------------------------------------------------------------------
module vga_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign dout_o = r_pipe[DEPTH-1];

endmodule

// File: rtl/vga_fb_scheduler.sv
// ---------------------------------------------------------------------------
// vga_fb_scheduler
// Arbitrates a single-port framebuffer RAM between the display fetch (fixed
// timing, absolute priority) and a host port, and manages double buffering.
// The front buffer is scanned out; the host only ever touches the back buffer.
//
// Ports
//   clk_i, reset_i                 : pixel clock, synchronous active-low reset
//   hsync_i, vsync_i, display_on_i : timing from vga_hvsync_gen
//   hpos_i, vpos_i                 : current pixel position; vpos_i is 11 bits
//                                    so that line V_ACTIVE (the swap line) is
//                                    representable
//   hsync_o, vsync_o, de_o         : timing delayed 2 cycles (fetch latency)
//   vga_r_o, vga_g_o, vga_b_o      : pixel colour, 0 outside de_o
//   host_*                         : host request / read response
//   swap_req_i, swap_busy_o,
//   swap_done_o                    : buffer swap request / pending / taken
//   mem_*                          : framebuffer RAM, 1-cycle read latency
//   dbg_state_o, dbg_fb_sel_o      : swap FSM state and front-buffer select
//
// Host handshake: a request transfers on any cycle where host_valid_i and
// host_ready_o are both high. host_ready_o is combinational and drops only on
// display fetch slots (and in reset); the host must hold its request until it
// transfers. An accepted read returns host_rvalid_o one cycle later.
// ---------------------------------------------------------------------------
module vga_fb_scheduler
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int SHIFT    = 3,
  parameter int AW       = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             hsync_i,
  input  logic             vsync_i,
  input  logic             display_on_i,
  input  logic [10:0]      hpos_i,
  input  logic [10:0]      vpos_i,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             de_o,
  output logic [3:0]       vga_r_o,
  output logic [3:0]       vga_g_o,
  output logic [3:0]       vga_b_o,
  input  logic             host_valid_i,
  output logic             host_ready_o,
  input  logic             host_we_i,
  input  logic [AW-2:0]    host_addr_i,
  input  logic [PIX_W-1:0] host_wdata_i,
  output logic             host_rvalid_o,
  output logic [PIX_W-1:0] host_rdata_o,
  input  logic             swap_req_i,
  output logic             swap_busy_o,
  output logic             swap_done_o,
  output logic             mem_en_o,
  output logic             mem_we_o,
  output logic [AW-1:0]    mem_addr_o,
  output logic [PIX_W-1:0] mem_wdata_o,
  input  logic [PIX_W-1:0] mem_rdata_i,
  output swap_state_t      dbg_state_o,
  output logic             dbg_fb_sel_o
);

  localparam int COLS     = H_ACTIVE >> SHIFT;
  localparam int ROWS     = V_ACTIVE >> SHIFT;
  localparam int FB_WORDS = COLS * ROWS;

  swap_state_t      r_state;
  swap_state_t      w_state_next;
  logic             r_fb_sel;
  logic             r_swap_done;
  logic             r_rvalid;
  logic             r_rd_zero;
  logic             r_disp_fetch;
  logic [PIX_W-1:0] r_pix;

  logic             w_disp_slot;
  logic             w_host_acc;
  logic             w_host_in_range;
  logic             w_host_mem;
  logic             w_swap_point;
  logic             w_swap_fire;
  logic [AW-1:0]    w_front_base;
  logic [AW-1:0]    w_back_base;
  logic [AW-1:0]    w_disp_addr;
  logic [AW-1:0]    w_host_addr;
  logic [2:0]       w_sync_dly;

  // ---------------- arbitration and address generation ----------------
  // One fetch per cell, on the first pixel of each cell during active video.
  assign w_disp_slot     = display_on_i && (hpos_i[SHIFT-1:0] == '0);
  assign host_ready_o    = reset_i && !w_disp_slot;
  assign w_host_acc      = host_valid_i && host_ready_o;
  // Out-of-range offsets are still accepted so the host never deadlocks;
  // they simply never reach the RAM.
  assign w_host_in_range = ({1'b0, host_addr_i} < AW'(FB_WORDS));
  assign w_host_mem      = w_host_acc && w_host_in_range;

  // Both bases follow the current fb_sel, so a host access on the swap
  // cycle still lands in the pre-swap back buffer.
  assign w_front_base = r_fb_sel ? AW'(FB_WORDS) : '0;
  assign w_back_base  = r_fb_sel ? '0 : AW'(FB_WORDS);
  assign w_disp_addr  = w_front_base + AW'(vpos_i >> SHIFT) * AW'(COLS)
                      + AW'(hpos_i >> SHIFT);
  assign w_host_addr  = w_back_base + {1'b0, host_addr_i};

  assign mem_en_o    = reset_i && (w_disp_slot || w_host_mem);
  assign mem_we_o    = w_host_mem && host_we_i;
  assign mem_addr_o  = w_disp_slot ? w_disp_addr : w_host_addr;
  assign mem_wdata_o = host_wdata_i;

  // ---------------- swap FSM ----------------
  assign w_swap_point = (vpos_i == 11'(V_ACTIVE)) && (hpos_i == '0);

  always_ff @(posedge clk_i) begin
    if (!reset_i) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (swap_req_i)   w_state_next = PEND;
      PEND:    if (w_swap_point) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    swap_busy_o = (r_state == PEND);
    w_swap_fire = (r_state == PEND) && w_swap_point;
  end

  // ---------------- registered state ----------------
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_fb_sel     <= 1'b0;
      r_swap_done  <= 1'b0;
      r_rvalid     <= 1'b0;
      r_rd_zero    <= 1'b0;
      r_disp_fetch <= 1'b0;
      r_pix        <= '0;
    end else begin
      if (w_swap_fire) r_fb_sel <= !r_fb_sel;
      r_swap_done  <= w_swap_fire;
      r_rvalid     <= w_host_acc && !host_we_i;
      r_rd_zero    <= !w_host_in_range;
      r_disp_fetch <= w_disp_slot;
      // RAM data for a fetch arrives one cycle after the slot.
      if (r_disp_fetch) r_pix <= mem_rdata_i;
    end
  end

  assign swap_done_o   = r_swap_done;
  assign host_rvalid_o = r_rvalid;
  assign host_rdata_o  = (r_rvalid && !r_rd_zero) ? mem_rdata_i : '0;
  assign dbg_state_o   = r_state;
  assign dbg_fb_sel_o  = r_fb_sel;

  // ---------------- output timing ----------------
  // Fetch (t) -> RAM data (t+1) -> pixel register (t+2); sync follows suit.
  vga_delay_line #(
    .WIDTH(3),
    .DEPTH(2)
  ) u_sync_dly (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .din_i  ({hsync_i, vsync_i, display_on_i}),
    .dout_o (w_sync_dly)
  );

  assign {hsync_o, vsync_o, de_o} = w_sync_dly;

  assign vga_r_o = de_o ? r_pix[11:8] : 4'h0;
  assign vga_g_o = de_o ? r_pix[7:4]  : 4'h0;
  assign vga_b_o = de_o ? r_pix[3:0]  : 4'h0;

endmodule
